sfp_vec_accum: RTL and testbench

//  Multi-channel successor of the single-lane special function processor.

---
 rtl/sfp_vec_accum_if.sv | 24 ++
 rtl/sfp_vec_accum.sv | 122 ++++++++++++
 tb/tb_sfp_vec_accum.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/sfp_vec_accum_if.sv
// Valid/ready stream bundle for the vector accumulator: partial-sum beats in,
// finished, saturated vectors out.
interface sfp_vec_accum_if #(
  parameter int NCH   = 8,
  parameter int IN_W  = 16,
  parameter int OUT_W = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;
  logic [NCH*IN_W-1:0]  in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [NCH*OUT_W-1:0] out_data;

  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sfp_vec_accum.sv
// NCH-lane partial-sum accumulator: saturating add per beat, then on the last
// beat shift, optional ReLU and clamp to OUT_W into a held output register.
module sfp_lane #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 32,
  parameter int OUT_W = 16,
  parameter int SH_W  = 5
) (
  input  logic                    clr,
  input  logic signed [ACC_W-1:0] acc_q,
  input  logic signed [IN_W-1:0]  din,
  input  logic [SH_W-1:0]         shift,
  input  logic                    relu_en,
  output logic signed [ACC_W-1:0] acc_sum,
  output logic                    acc_sat,
  output logic signed [OUT_W-1:0] out_val,
  output logic                    out_sat
);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W:0]   wide;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] shr;

  always_comb begin
    base    = clr ? '0 : acc_q;
    // One guard bit exposes ACC_W overflow as a sign mismatch.
    wide    = {base[ACC_W-1], base} + {{(ACC_W+1-IN_W){din[IN_W-1]}}, din};
    acc_sat = wide[ACC_W] ^ wide[ACC_W-1];
    acc_sum = acc_sat ? (wide[ACC_W] ? ACC_MIN : ACC_MAX) : wide[ACC_W-1:0];
    shr     = acc_sum >>> shift;
    if (relu_en && shr[ACC_W-1]) shr = '0;
    // Fits in OUT_W only if all bits above the OUT_W sign bit replicate it.
    out_sat = !((&shr[ACC_W-1:OUT_W-1]) || (~|shr[ACC_W-1:OUT_W-1]));
    out_val = out_sat ? (shr[ACC_W-1] ? OUT_MIN : OUT_MAX) : shr[OUT_W-1:0];
  end
endmodule

module sfp_vec_accum #(
  parameter int NCH   = 8,
  parameter int IN_W  = 16,
  parameter int ACC_W = 32,
  parameter int OUT_W = 16,
  parameter int SH_W  = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   acc_clear,
  input  logic                   relu_en,
  input  logic [SH_W-1:0]        shift,
  sfp_vec_accum_if.slave         bus,
  output logic                   sat_flag,
  output logic [15:0]            vec_count
);
  logic [NCH-1:0][ACC_W-1:0] acc_q, acc_d, lane_sum;
  logic [NCH-1:0][OUT_W-1:0] lane_out;
  logic [NCH-1:0]            lane_acc_sat, lane_out_sat;
  logic [NCH*OUT_W-1:0]      out_data_q, out_data_d;
  logic                      out_valid_q, out_valid_d;
  logic                      sat_q, sat_d;
  logic [15:0]               cnt_q, cnt_d;
  logic                      beat, handoff;

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    sfp_lane #(.IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SH_W(SH_W)) u_lane (
      .clr     (acc_clear),
      .acc_q   (acc_q[c]),
      .din     (bus.in_data[c*IN_W +: IN_W]),
      .shift   (shift),
      .relu_en (relu_en),
      .acc_sum (lane_sum[c]),
      .acc_sat (lane_acc_sat[c]),
      .out_val (lane_out[c]),
      .out_sat (lane_out_sat[c])
    );
  end

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign sat_flag      = sat_q;
  assign vec_count     = cnt_q;
  assign beat          = bus.in_valid && bus.in_ready;
  assign handoff       = out_valid_q && bus.out_ready;

  always_comb begin
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q + {15'd0, handoff};
    sat_d       = (acc_clear ? 1'b0 : sat_q)
                | (beat && ((|lane_acc_sat) || (bus.in_last && (|lane_out_sat))));
    if (beat) acc_d = bus.in_last ? '0 : lane_sum;
    else if (acc_clear) acc_d = '0;
    // A new last beat during a handoff replaces the vector without a bubble.
    if (beat && bus.in_last) begin
      out_data_d  = lane_out;
      out_valid_d = 1'b1;
    end else if (handoff) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule

// File: tb/tb_sfp_vec_accum.sv
// Bench for sfp_vec_accum: table of single-lane vectors plus hand sequences for
// stall, back-to-back, clear-with-beat and mid-vector reset; outputs scoreboarded.
module tb_sfp_vec_accum;
  localparam int NCH = 8, IN_W = 16, OUT_W = 16;

  logic        clk = 0, reset = 1, acc_clear = 0, relu_en = 0;
  logic [4:0]  shift = 0;
  logic        sat_flag;
  logic [15:0] vec_count;

  sfp_vec_accum_if #(.NCH(NCH), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  sfp_vec_accum dut (
    .clk(clk), .reset(reset), .acc_clear(acc_clear), .relu_en(relu_en),
    .shift(shift), .bus(bus), .sat_flag(sat_flag), .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lane; int nb; int v0; int v1; int v2;
    int sh; bit relu; bit clr; int exp; bit exp_sat;
  } rec_t;

  rec_t                 tbl[8];
  logic [NCH*OUT_W-1:0] sb[$];
  int                   n_pass = 0, n_tot = 0, stalls = 0;
  logic [15:0]          exp_cnt = 0, cnt_base = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every handoff must match the oldest expected vector.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) chk("unexpected_output", bus.out_data, '1);
      else chk("out_data", bus.out_data, sb.pop_front());
      exp_cnt <= exp_cnt + 16'd1;
    end
  end

  function automatic logic [NCH*IN_W-1:0] lane_in(input int lane, input int v);
    logic [NCH*IN_W-1:0] d = '0;
    d[lane*IN_W +: IN_W] = v[IN_W-1:0];
    return d;
  endfunction

  function automatic logic [NCH*OUT_W-1:0] lane_out(input int lane, input int v);
    logic [NCH*OUT_W-1:0] d = '0;
    d[lane*OUT_W +: OUT_W] = v[OUT_W-1:0];
    return d;
  endfunction

  // Drive one beat from posedge+1; returns at posedge+1 after acceptance.
  task automatic send(input logic [NCH*IN_W-1:0] d, input logic last, input logic clr,
                      input int sh, input logic relu);
    int t = 0;
    bus.in_valid = 1; bus.in_data = d; bus.in_last = last;
    acc_clear = clr; shift = sh[4:0]; relu_en = relu;
    if (!bus.in_ready) stalls++;
    while (!bus.in_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 0; bus.in_last = 0; acc_clear = 0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 50) begin @(posedge clk); t++; end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    #1;
  endtask

  initial begin
    logic [NCH*OUT_W-1:0] e;
    logic [15:0] c0;
    bus.in_valid = 0; bus.in_last = 0; bus.in_data = '0; bus.out_ready = 1;

    tbl[0] = '{0, 3, 10, 20, 30, 0, 0, 1, 60, 0};
    tbl[1] = '{1, 2, -5, -7, 0, 0, 1, 0, 0, 0};
    tbl[2] = '{1, 2, -5, -7, 0, 0, 0, 0, -12, 0};
    tbl[3] = '{2, 2, 30000, 30000, 0, 0, 0, 0, 32767, 1};
    tbl[4] = '{2, 2, 30000, 30000, 0, 2, 0, 1, 15000, 0};
    tbl[5] = '{3, 2, -30000, -30000, 0, 0, 0, 1, -32768, 1};
    tbl[6] = '{4, 3, 100, -100, 5, 1, 1, 1, 2, 0};
    tbl[7] = '{5, 1, -7, 0, 0, 1, 0, 1, -4, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_sat_flag", sat_flag, 0);
    chk("rst_vec_count", vec_count, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    reset = 0;

    for (int i = 0; i < 8; i++) begin
      int v[3];
      v[0] = tbl[i].v0; v[1] = tbl[i].v1; v[2] = tbl[i].v2;
      if (tbl[i].clr) begin
        acc_clear = 1; @(posedge clk); #1; acc_clear = 0;
      end
      sb.push_back(lane_out(tbl[i].lane, tbl[i].exp));
      for (int b = 0; b < tbl[i].nb; b++)
        send(lane_in(tbl[i].lane, v[b]), b == tbl[i].nb - 1, 0, tbl[i].sh, tbl[i].relu);
      drain();
      chk($sformatf("tbl%0d_sat_flag", i), sat_flag, tbl[i].exp_sat);
    end
    chk("tbl_vec_count", vec_count, exp_cnt - cnt_base);

    // Stall: output held while the consumer is not ready.
    bus.out_ready = 0;
    e = lane_out(0, 9);
    sb.push_back(e);
    send(lane_in(0, 9), 1, 0, 0, 0);
    chk("latency_out_valid", bus.out_valid, 1);
    c0 = vec_count;
    for (int k = 0; k < 5; k++) begin
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_out_data", bus.out_data, e);
      @(posedge clk); #1;
    end
    chk("stall_vec_count", vec_count, c0);
    bus.out_ready = 1;
    drain();
    chk("stall_release_count", vec_count, c0 + 16'd1);
    chk("stall_release_valid", bus.out_valid, 0);

    // Back-to-back single-beat vectors at full rate.
    c0 = vec_count; stalls = 0;
    for (int k = 1; k <= 3; k++) begin
      sb.push_back(lane_out(6, k));
      send(lane_in(6, k), 1, 0, 0, 0);
    end
    drain();
    chk("b2b_no_stall", stalls, 0);
    chk("b2b_vec_count", vec_count, c0 + 16'd3);

    // acc_clear coinciding with a beat: clear first, then add.
    send(lane_in(0, 100), 0, 0, 0, 0);
    send(lane_in(0, 100), 0, 0, 0, 0);
    send(lane_in(0, 7), 0, 1, 0, 0);
    sb.push_back(lane_out(0, 8));
    send(lane_in(0, 1), 1, 0, 0, 0);
    drain();

    // Reset mid-vector after setting sat_flag.
    sb.push_back(lane_out(2, 32767));
    send(lane_in(2, 30000), 0, 0, 0, 0);
    send(lane_in(2, 30000), 1, 0, 0, 0);
    drain();
    chk("pre_reset_sat", sat_flag, 1);
    send(lane_in(0, 50), 0, 0, 0, 0);
    send(lane_in(0, 50), 0, 0, 0, 0);
    reset = 1; @(posedge clk); #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_out_data", bus.out_data, 0);
    chk("mid_rst_sat", sat_flag, 0);
    chk("mid_rst_vec_count", vec_count, 0);
    reset = 0; cnt_base = exp_cnt;
    sb.push_back(lane_out(0, 5));
    send(lane_in(0, 5), 1, 0, 0, 0);
    drain();
    chk("post_rst_vec_count", vec_count, exp_cnt - cnt_base);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
